// File: rtl/reset_request_gen_pkg.sv
// +-----------------------------------------------------------------------------+
// | Module   : reset_pkg                                                        |
// | Brief    : Shared types and helpers for the reset request generator.        |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
`default_nettype none

package reset_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        FIRE     = 2'd2,
        HOLDOFF  = 2'd3
    } rstreq_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_BUTTON = 2'b01,
        CAUSE_SOFT   = 2'b10,
        CAUSE_WDT    = 2'b11
    } rst_cause_t;

    // A count limit of 1 still needs a 1-bit register.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reset_request_gen_if.sv
// +-----------------------------------------------------------------------------+
// | Module   : reset_request_gen_if                                             |
// | Brief    : Request inputs and trigger/status outputs of the reset requester.|
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface reset_request_gen_if;
    import reset_pkg::*;

    logic       ButtonIn;
    logic       SoftRstReq;
    logic       WatchdogKick;
    logic       sync_rst_Trigger;
    rst_cause_t RstCause;
    logic       Busy;

    modport master (
        output ButtonIn,
        output SoftRstReq,
        output WatchdogKick,
        input  sync_rst_Trigger,
        input  RstCause,
        input  Busy
    );

    modport slave (
        input  ButtonIn,
        input  SoftRstReq,
        input  WatchdogKick,
        output sync_rst_Trigger,
        output RstCause,
        output Busy
    );

endinterface

`default_nettype wire

// File: rtl/reset_request_gen_sync.sv
// +-----------------------------------------------------------------------------+
// | Module   : button_sync_debounce                                             |
// | Brief    : Button synchroniser chain plus pressed-polarity decode.          |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
`default_nettype none

module button_sync_debounce #(
    parameter int SYNCSTAGES      = 2,
    parameter int BUTTONACTIVELOW = 1
) (
    input  logic clk,
    input  logic sync_rst,
    input  logic button_i,
    output logic pressed_o
);

    localparam int   C_STAGES   = (SYNCSTAGES < 2) ? 2 : SYNCSTAGES;
    localparam logic C_RELEASED = (BUTTONACTIVELOW != 0);

    logic [C_STAGES-1:0] sync_q;

    // Free-running: the chain ignores clk_en so metastability settles regardless.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            sync_q <= {C_STAGES{C_RELEASED}};
        end else begin
            sync_q <= {sync_q[C_STAGES-2:0], button_i};
        end
    end

    assign pressed_o = sync_q[C_STAGES-1] ^ C_RELEASED;

endmodule

`default_nettype wire

// File: rtl/reset_request_gen.sv
// +-----------------------------------------------------------------------------+
// | Module   : reset_request_gen                                                |
// | Brief    : Button/soft/watchdog reset requester issuing a one-cycle trigger.|
// |            Watchdog built only when RESET_REQUEST_WATCHDOG_EN is defined.   |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
`default_nettype none

module reset_request_gen
    import reset_pkg::*;
#(
    parameter int DEBOUNCECYCLES  = 250000,
    parameter int HOLDOFFCYCLES   = 25000,
    parameter int WATCHDOGCYCLES  = 2500000,
    parameter int SYNCSTAGES      = 2,
    parameter int BUTTONACTIVELOW = 1
) (
    input  logic                 clk,
    input  logic                 sync_rst,
    input  logic                 clk_en,
    reset_request_gen_if.slave   bus
);

    localparam int C_DB_W = cnt_width(DEBOUNCECYCLES);
    localparam int C_HO_W = cnt_width(HOLDOFFCYCLES);
    localparam logic [C_DB_W-1:0] C_DB_MAX = C_DB_W'(DEBOUNCECYCLES - 1);
    localparam logic [C_HO_W-1:0] C_HO_MAX = C_HO_W'(HOLDOFFCYCLES - 1);

    rstreq_state_t       state_q,  state_d;
    rst_cause_t          cause_q,  cause_d;
    logic                trig_q,   trig_d;
    logic [C_DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [C_HO_W-1:0]   ho_cnt_q, ho_cnt_d;
    logic                w_pressed;
    logic                w_wd_expired;

    button_sync_debounce #(
        .SYNCSTAGES      (SYNCSTAGES),
        .BUTTONACTIVELOW (BUTTONACTIVELOW)
    ) u_sync (
        .clk       (clk),
        .sync_rst  (sync_rst),
        .button_i  (bus.ButtonIn),
        .pressed_o (w_pressed)
    );

`ifdef RESET_REQUEST_WATCHDOG_EN
    localparam int C_WD_W = cnt_width(WATCHDOGCYCLES);
    localparam logic [C_WD_W-1:0] C_WD_MAX = C_WD_W'(WATCHDOGCYCLES - 1);

    logic [C_WD_W-1:0] wd_cnt_q, wd_cnt_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (bus.WatchdogKick || (state_q == FIRE) || (state_q == HOLDOFF)) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != C_WD_MAX) begin
            wd_cnt_d = wd_cnt_q + C_WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            wd_cnt_q <= '0;
        end else if (clk_en) begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    // A kick landing on the terminal count wins over expiry.
    assign w_wd_expired = (wd_cnt_q == C_WD_MAX) && !bus.WatchdogKick;
`else
    logic w_unused_wd;
    assign w_unused_wd  = bus.WatchdogKick | (WATCHDOGCYCLES == 0);
    assign w_wd_expired = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        db_cnt_d = db_cnt_q;
        ho_cnt_d = ho_cnt_q;
        case (state_q)
            IDLE: begin
                db_cnt_d = '0;
                ho_cnt_d = '0;
                if (w_pressed) begin
                    state_d = DEBOUNCE;
                end else if (bus.SoftRstReq) begin
                    state_d = FIRE;
                    cause_d = CAUSE_SOFT;
                end else if (w_wd_expired) begin
                    state_d = FIRE;
                    cause_d = CAUSE_WDT;
                end
            end
            DEBOUNCE: begin
                if (bus.SoftRstReq) begin
                    state_d  = FIRE;
                    cause_d  = CAUSE_SOFT;
                    db_cnt_d = '0;
                end else if (!w_pressed) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == C_DB_MAX) begin
                    state_d  = FIRE;
                    cause_d  = CAUSE_BUTTON;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + C_DB_W'(1);
                end
            end
            FIRE: begin
                state_d  = HOLDOFF;
                ho_cnt_d = '0;
            end
            HOLDOFF: begin
                // A still-held button parks here so it cannot retrigger.
                if (ho_cnt_q != C_HO_MAX) begin
                    ho_cnt_d = ho_cnt_q + C_HO_W'(1);
                end else if (!w_pressed) begin
                    state_d  = IDLE;
                    ho_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign trig_d = (state_d == FIRE);

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q  <= IDLE;
            cause_q  <= CAUSE_NONE;
            trig_q   <= 1'b0;
            db_cnt_q <= '0;
            ho_cnt_q <= '0;
        end else if (clk_en) begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            trig_q   <= trig_d;
            db_cnt_q <= db_cnt_d;
            ho_cnt_q <= ho_cnt_d;
        end
    end

    assign bus.sync_rst_Trigger = trig_q;
    assign bus.RstCause         = cause_q;
    assign bus.Busy             = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_reset_request_gen.sv
// +-----------------------------------------------------------------------------+
// | Module   : tb_reset_request_gen                                             |
// | Brief    : Directed bench with an event-level reference model.              |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_reset_request_gen;

    localparam int DB = 4;
    localparam int HO = 8;
    localparam int WD = 16;
`ifdef RESET_REQUEST_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic clk      = 1'b0;
    logic sync_rst = 1'b1;
    logic clk_en   = 1'b1;

    reset_request_gen_if bus();

    reset_request_gen #(
        .DEBOUNCECYCLES  (DB),
        .HOLDOFFCYCLES   (HO),
        .WATCHDOGCYCLES  (WD),
        .SYNCSTAGES      (2),
        .BUTTONACTIVELOW (1)
    ) dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .clk_en   (clk_en),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int total     = 0;
    int bad       = 0;
    int trig_seen = 0;
    bit checking  = 1'b0;

    // Reference model: what has been seen, not how the RTL stores it.
    bit m_seen[2];      // pressed samples, [0] newest
    bit m_fire;         // trigger cycle in progress
    bit m_hold;         // lockout after a trigger
    int m_ho;           // lockout cycles elapsed
    int m_db;           // consecutive pressed cycles counted, -1 when not debouncing
    int m_wd;           // cycles since last kick/lockout
    int m_cause;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pressed;
        bit fire_now;
        int new_cause;
        pressed   = m_seen[1];
        fire_now  = 1'b0;
        new_cause = 0;
        if (sync_rst) begin
            m_seen = '{1'b0, 1'b0};
            m_fire = 1'b0; m_hold = 1'b0;
            m_ho = 0; m_db = -1; m_wd = 0; m_cause = 0;
        end else begin
            m_seen[1] = m_seen[0];
            m_seen[0] = (bus.ButtonIn == 1'b0);
            if (clk_en) begin
                if (m_fire) begin
                    m_fire = 1'b0; m_hold = 1'b1; m_ho = 0; m_wd = 0;
                end else if (m_hold) begin
                    m_wd = 0;
                    if (m_ho < HO - 1) m_ho++;
                    else if (!pressed) m_hold = 1'b0;
                end else begin
                    if (m_db >= 0) begin
                        if (bus.SoftRstReq) begin fire_now = 1'b1; new_cause = 2; end
                        else if (!pressed) m_db = -1;
                        else if (m_db == DB - 1) begin fire_now = 1'b1; new_cause = 1; end
                        else m_db++;
                    end else begin
                        if (pressed) m_db = 0;
                        else if (bus.SoftRstReq) begin fire_now = 1'b1; new_cause = 2; end
                        else if (WD_ON && m_wd == WD - 1 && !bus.WatchdogKick) begin
                            fire_now = 1'b1; new_cause = 3;
                        end
                    end
                    if (bus.WatchdogKick) m_wd = 0;
                    else if (m_wd < WD - 1) m_wd++;
                    if (fire_now) begin
                        m_fire = 1'b1; m_db = -1; m_cause = new_cause;
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("trigger", int'(bus.sync_rst_Trigger), int'(m_fire));
            chk("cause",   int'(bus.RstCause),         m_cause);
            chk("busy",    int'(bus.Busy),             int'(m_fire || m_hold || (m_db >= 0)));
            if (bus.sync_rst_Trigger) trig_seen++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic wait_trig(input int limit, output int n);
        n = 0;
        while (bus.sync_rst_Trigger !== 1'b1 && n < limit) begin
            cyc(1);
            n++;
        end
    endtask

    task automatic do_reset();
        sync_rst = 1'b1;
        cyc(2);
        sync_rst = 1'b0;
    endtask

    initial begin
        int n;
        int t0;
        bus.ButtonIn     = 1'b1;
        bus.SoftRstReq   = 1'b0;
        bus.WatchdogKick = 1'b1;
        m_db = -1;
        @(negedge clk);
        cyc(1);
        checking = 1'b1;
        cyc(1);
        sync_rst = 1'b0;
        chk("reset_trig",  int'(bus.sync_rst_Trigger), 0);
        chk("reset_cause", int'(bus.RstCause), 0);
        chk("reset_busy",  int'(bus.Busy), 0);

        // 1) ten-cycle press
        t0 = trig_seen;
        bus.ButtonIn = 1'b0;
        wait_trig(20, n);
        chk("t1_latency", n, 7);
        chk("t1_cause", int'(bus.RstCause), 1);
        cyc(1);
        chk("t1_pulse_width", int'(bus.sync_rst_Trigger), 0);
        cyc(2);
        bus.ButtonIn = 1'b1;
        cyc(20);
        chk("t1_trig_count", trig_seen - t0, 1);

        // 2) short bounces never fire
        do_reset();
        t0 = trig_seen;
        for (int i = 0; i < 5; i++) begin
            bus.ButtonIn = 1'b0; cyc(3);
            bus.ButtonIn = 1'b1; cyc(3);
        end
        cyc(4);
        chk("t2_trig_count", trig_seen - t0, 0);
        chk("t2_cause", int'(bus.RstCause), 0);
        chk("t2_idle", int'(bus.Busy), 0);

        // 3) soft request, second one inside lockout ignored
        t0 = trig_seen;
        bus.SoftRstReq = 1'b1; cyc(1); bus.SoftRstReq = 1'b0;
        chk("t3_trig", int'(bus.sync_rst_Trigger), 1);
        chk("t3_cause", int'(bus.RstCause), 2);
        cyc(2);
        bus.SoftRstReq = 1'b1; cyc(1); bus.SoftRstReq = 1'b0;
        cyc(20);
        chk("t3_trig_count", trig_seen - t0, 1);

        // 4) watchdog
        t0 = trig_seen;
        bus.WatchdogKick = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.WatchdogKick = 1'b1; cyc(1);
            bus.WatchdogKick = 1'b0; cyc(9);
        end
        chk("t4_kicked_no_trig", trig_seen - t0, 0);
        bus.WatchdogKick = 1'b1; cyc(1); bus.WatchdogKick = 1'b0;
        wait_trig(40, n);
        chk("t4_wdt_latency", n, WD_ON ? 16 : 40);
        chk("t4_cause", int'(bus.RstCause), WD_ON ? 3 : 2);
        bus.WatchdogKick = 1'b1;
        cyc(20);

        // 5) long hold fires once, idle right after release clears the chain
        do_reset();
        t0 = trig_seen;
        bus.ButtonIn = 1'b0;
        cyc(40);
        bus.ButtonIn = 1'b1;
        cyc(2);
        chk("t5_busy_held", int'(bus.Busy), 1);
        cyc(1);
        chk("t5_idle_after_release", int'(bus.Busy), 0);
        chk("t5_trig_count", trig_seen - t0, 1);
        chk("t5_cause", int'(bus.RstCause), 1);

        // 6) clk_en freeze in FIRE, then reset mid-FIRE
        do_reset();
        bus.SoftRstReq = 1'b1; cyc(1); bus.SoftRstReq = 1'b0;
        chk("t6_fire", int'(bus.sync_rst_Trigger), 1);
        clk_en = 1'b0;
        cyc(3);
        chk("t6_frozen_trig", int'(bus.sync_rst_Trigger), 1);
        clk_en = 1'b1;
        cyc(1);
        chk("t6_released_trig", int'(bus.sync_rst_Trigger), 0);
        cyc(12);
        bus.SoftRstReq = 1'b1; cyc(1); bus.SoftRstReq = 1'b0;
        chk("t6_fire2", int'(bus.sync_rst_Trigger), 1);
        sync_rst = 1'b1;
        cyc(1);
        chk("t6_rst_trig",  int'(bus.sync_rst_Trigger), 0);
        chk("t6_rst_busy",  int'(bus.Busy), 0);
        chk("t6_rst_cause", int'(bus.RstCause), 0);
        sync_rst = 1'b0;
        cyc(3);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
